// File: rtl/rx_tlp_sender.sv
// Turns RX trigger requests into 64-bit MWr (4DW) TLPs that copy RX buffer qwords into host huge pages.
// Latency: first header beat one cycle after acceptance; data beats stream back to back when tready stays high.
// Backpressure: tready stalls hold the output beat; one holding register catches the in-flight buffer read.

`ifndef BF
`define BF 9
`endif

module rx_tlp_sender #(
   parameter int HDR_QW       = 16,
   parameter int PAGE_QW_BITS = 18
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          trigger_tlp,
   input  logic          send_last_tlp,
   input  logic          change_huge_page,
   input  logic [4:0]    qwords_to_send,
   output logic          trigger_tlp_ack,
   output logic          change_huge_page_ack,
   output logic [`BF:0]  commited_rd_address,
   output logic [`BF:0]  rd_addr,
   input  logic [63:0]   rd_data,
   input  logic [63:0]   huge_page_addr_1,
   input  logic [63:0]   huge_page_addr_2,
   input  logic          huge_page_status_1,
   input  logic          huge_page_status_2,
   output logic          huge_page_free_1,
   output logic          huge_page_free_2,
   input  logic [15:0]   cfg_completer_id,
   input  logic          s_axis_tx_tready,
   output logic          s_axis_tx_tvalid,
   output logic [63:0]   s_axis_tx_tdata,
   output logic [7:0]    s_axis_tx_tkeep,
   output logic          s_axis_tx_tlast
);

   localparam int AW = `BF + 1;
   localparam int OW = PAGE_QW_BITS + 1;

   typedef enum logic [3:0] {
      S_IDLE, S_HDR0, S_HDR1, S_DATA, S_DONE,
      S_CLOSE_HDR0, S_CLOSE_HDR1, S_CLOSE_DATA, S_CLOSE_DONE, S_WAIT
   } state_t;

   state_t          state, state_nxt;
   logic            cur_page;          // 0 = page 1, 1 = page 2
   logic [OW-1:0]   page_qw_offset;
   logic [4:0]      qw_len;
   logic [4:0]      fetch_cnt;
   logic            req_last;
   logic [AW-1:0]   commit_q;
   logic [AW-1:0]   rd_addr_q;

   // output beat register, holding register and the one-deep read pipe
   logic            out_vld, out_last, hold_vld, hold_last, rd_pend, rd_pend_last;
   logic [63:0]     out_dat, hold_dat;

   logic            pop, o_free, page_ok, accept, fetch, hdr_load, hdr_last;
   logic [63:0]     hdr_dat, page_base, tlp_addr;
   logic [1:0]      occ;

   // DW0 = MWr 4DW (fmt 11, type 0), length in DW; DW1 = requester id, tag 0, BEs 0xF
   function automatic logic [63:0] mk_hdr0(input logic [15:0] rid, input logic [4:0] qw);
      return {rid, 16'h00FF, 22'h180000, 4'b0000, qw, 1'b0};
   endfunction

   assign pop       = out_vld & s_axis_tx_tready;
   assign o_free    = ~out_vld | s_axis_tx_tready;
   assign page_ok   = cur_page ? huge_page_status_2 : huge_page_status_1;
   assign page_base = cur_page ? huge_page_addr_2 : huge_page_addr_1;
   assign tlp_addr  = page_base + 64'({page_qw_offset, 3'b000});
   // beats that will sit in out/hold after this edge, plus the read landing next cycle
   assign occ       = {1'b0, out_vld & ~s_axis_tx_tready} + {1'b0, hold_vld} + {1'b0, rd_pend};

   // next-state decode and beat/fetch generation
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      hdr_load  = 1'b0;
      hdr_dat   = '0;
      hdr_last  = 1'b0;
      fetch     = 1'b0;
      case (state)
         S_IDLE: begin
            if (page_ok && (change_huge_page || send_last_tlp || trigger_tlp)) begin
               accept = 1'b1;
               if (change_huge_page || (send_last_tlp && qwords_to_send == 5'd0))
                  state_nxt = S_CLOSE_HDR0;
               else
                  state_nxt = S_HDR0;
            end
         end
         S_HDR0: begin
            if (o_free) begin
               hdr_load  = 1'b1;
               hdr_dat   = mk_hdr0(cfg_completer_id, qw_len);
               state_nxt = S_HDR1;
            end
         end
         S_HDR1: begin
            // first fetch goes out with header beat 1 so data follows without a bubble
            if (o_free) begin
               hdr_load  = 1'b1;
               hdr_dat   = {tlp_addr[31:0], tlp_addr[63:32]};
               fetch     = 1'b1;
               state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            fetch = (fetch_cnt < qw_len) && (occ < 2'd2);
            if (pop && out_last)
               state_nxt = S_DONE;
         end
         S_DONE:
            state_nxt = req_last ? S_CLOSE_HDR0 : S_WAIT;
         S_CLOSE_HDR0: begin
            if (o_free) begin
               hdr_load  = 1'b1;
               hdr_dat   = mk_hdr0(cfg_completer_id, 5'd1);
               state_nxt = S_CLOSE_HDR1;
            end
         end
         S_CLOSE_HDR1: begin
            if (o_free) begin
               hdr_load  = 1'b1;
               hdr_dat   = {page_base[31:0], page_base[63:32]};
               state_nxt = S_CLOSE_DATA;
            end
         end
         S_CLOSE_DATA: begin
            // payload is loaded once; leave when that last beat is taken
            if (out_vld && out_last) begin
               if (s_axis_tx_tready)
                  state_nxt = S_CLOSE_DONE;
            end else if (o_free) begin
               hdr_load = 1'b1;
               hdr_dat  = {32'b0, 32'(page_qw_offset - OW'(HDR_QW))};
               hdr_last = 1'b1;
            end
         end
         S_CLOSE_DONE: state_nxt = S_WAIT;
         S_WAIT:       state_nxt = S_IDLE;
         default:      state_nxt = S_IDLE;
      endcase
   end

   // FSM state, request latching, read address and page bookkeeping
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         cur_page       <= 1'b0;
         page_qw_offset <= OW'(HDR_QW);
         qw_len         <= '0;
         fetch_cnt      <= '0;
         req_last       <= 1'b0;
         commit_q       <= '0;
         rd_addr_q      <= '0;
         rd_pend        <= 1'b0;
         rd_pend_last   <= 1'b0;
      end else begin
         state        <= state_nxt;
         rd_pend      <= fetch;
         rd_pend_last <= fetch && (fetch_cnt == qw_len - 5'd1);
         if (accept) begin
            qw_len    <= change_huge_page ? 5'd0 : qwords_to_send;
            req_last  <= change_huge_page | send_last_tlp;
            rd_addr_q <= commit_q;
            fetch_cnt <= '0;
         end else if (fetch) begin
            rd_addr_q <= rd_addr_q + AW'(1);
            fetch_cnt <= fetch_cnt + 5'd1;
         end
         if (state == S_DONE) begin
            commit_q       <= commit_q + AW'(qw_len);
            page_qw_offset <= page_qw_offset + OW'(qw_len);
         end else if (state == S_CLOSE_DONE) begin
            cur_page       <= ~cur_page;
            page_qw_offset <= OW'(HDR_QW);
         end
      end
   end

   // output beat register fed in order from hold register, read pipe, then FSM headers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_vld   <= 1'b0;
         out_last  <= 1'b0;
         out_dat   <= '0;
         hold_vld  <= 1'b0;
         hold_last <= 1'b0;
         hold_dat  <= '0;
      end else if (o_free) begin
         if (hold_vld) begin
            out_vld   <= 1'b1;
            out_dat   <= hold_dat;
            out_last  <= hold_last;
            hold_vld  <= rd_pend;
            hold_dat  <= rd_data;
            hold_last <= rd_pend_last;
         end else if (rd_pend) begin
            out_vld  <= 1'b1;
            out_dat  <= rd_data;
            out_last <= rd_pend_last;
         end else if (hdr_load) begin
            out_vld  <= 1'b1;
            out_dat  <= hdr_dat;
            out_last <= hdr_last;
         end else begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
         end
      end else if (rd_pend) begin
         hold_vld  <= 1'b1;
         hold_dat  <= rd_data;
         hold_last <= rd_pend_last;
      end
   end

   assign s_axis_tx_tvalid     = out_vld;
   assign s_axis_tx_tdata      = out_dat;
   assign s_axis_tx_tkeep      = {8{out_vld}};
   assign s_axis_tx_tlast      = out_vld & out_last;
   assign rd_addr              = rd_addr_q;
   assign commited_rd_address  = commit_q;
   assign trigger_tlp_ack      = (state == S_DONE) && !req_last;
   assign change_huge_page_ack = (state == S_CLOSE_DONE);
   assign huge_page_free_1     = (state == S_CLOSE_DONE) && !cur_page;
   assign huge_page_free_2     = (state == S_CLOSE_DONE) && cur_page;

endmodule
